serial_record_loader: RTL

- Parametrised successor to the single-width serial RAM loader.
- Deserialises a bit-serial stream of training records into full-width words and writes them to a record RAM through a valid/ready write port.
- Each record is (feat+1) words of WORD_W bits: features plus y value.
- Sits between the host serial link and the dataset RAM that feeds the regression datapath. Adds start/busy control, input and output flow control, and a runtime record count.

---
 rtl/serial_record_loader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/serial_record_loader.sv
// Bit-serial to record-word loader feeding the dataset RAM through a valid/ready write port.
// Define SER_PARITY_EN to add a trailing even-parity bit per record and the par_err output.
module serial_record_loader #(
  parameter int ADDR_W       = 12,
  parameter int MAX_FEATURES = 15,
  parameter int WORD_W       = 16,
  parameter int FEAT_W       = 4
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  start,
  input  logic [ADDR_W:0]                       num_dp,
  input  logic [FEAT_W-1:0]                     feat,
  input  logic                                  ser,
  input  logic                                  ser_valid,
  output logic                                  ser_ready,
  output logic                                  wr_en,
  input  logic                                  wr_ready,
  output logic [ADDR_W-1:0]                     wr_addr,
  output logic [WORD_W*(MAX_FEATURES+1)-1:0]    wr_data,
  output logic                                  half_flag,
  output logic                                  busy,
  output logic                                  done
`ifdef SER_PARITY_EN
  ,
  output logic                                  par_err
`endif
);

  localparam int DATA_W = WORD_W * (MAX_FEATURES + 1);
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int IDX_W  = $clog2(DATA_W);

  localparam logic [ADDR_W:0]   NUM_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   NUM_ONE  = (ADDR_W+1)'(1);
  localparam logic [FEAT_W-1:0] FEAT_MAX = FEAT_W'(MAX_FEATURES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_DATA = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]   rec_idx_q, rec_idx_d;
  logic [ADDR_W:0]     num_q, num_d;
  logic [CNT_W-1:0]    rec_bits_q, rec_bits_d;
  logic [CNT_W-1:0]    base_q, base_d;
  logic                half_q, half_d;
  logic                ser_ready_q, wr_en_q, busy_q, done_q;
`ifdef SER_PARITY_EN
  logic                par_q, par_d;
  logic                par_err_q, par_err_d;
`endif

  logic [ADDR_W:0]     num_c;
  logic [FEAT_W-1:0]   feat_c;
  logic [CNT_W-1:0]    rec_bits_c;
  logic [CNT_W-1:0]    half_idx;
  logic [IDX_W-1:0]    idx;
  logic                last_rec;

  // Start-time clamps keep the record index from wrapping and the record inside the bus.
  assign num_c      = (num_dp > NUM_MAX) ? NUM_MAX : num_dp;
  assign feat_c     = (feat > FEAT_MAX) ? FEAT_MAX : feat;
  assign rec_bits_c = CNT_W'(WORD_W * (int'(feat_c) + 1));
  assign half_idx   = (rec_bits_q >> 1) - CNT_ONE;
  assign idx        = IDX_W'(base_q + bit_cnt_q);
  assign last_rec   = (({1'b0, rec_idx_q} + NUM_ONE) == num_q);

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    rec_idx_d  = rec_idx_q;
    num_d      = num_q;
    rec_bits_d = rec_bits_q;
    base_d     = base_q;
    half_d     = half_q;
`ifdef SER_PARITY_EN
    par_d      = par_q;
    par_err_d  = 1'b0;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          num_d      = num_c;
          rec_bits_d = rec_bits_c;
          base_d     = CNT_DATA - rec_bits_c;
          rec_idx_d  = '0;
          shreg_d    = '0;
          bit_cnt_d  = '0;
          half_d     = 1'b0;
`ifdef SER_PARITY_EN
          par_d      = 1'b0;
`endif
          state_d    = (num_c == '0) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        if (ser_valid) begin
          if (bit_cnt_q != rec_bits_q) begin
            shreg_d[idx] = ser;
            bit_cnt_d    = bit_cnt_q + CNT_ONE;
`ifdef SER_PARITY_EN
            par_d        = par_q ^ ser;
`endif
            if (last_rec && (bit_cnt_q == half_idx)) begin
              half_d = 1'b1;
            end
          end
`ifdef SER_PARITY_EN
          // Trailing parity bit: a mismatch drops the attempt and waits for a resend.
          if (bit_cnt_q == rec_bits_q) begin
            if (ser != par_q) begin
              par_err_d = 1'b1;
              shreg_d   = '0;
              bit_cnt_d = '0;
              par_d     = 1'b0;
            end else begin
              state_d = WRITE;
            end
          end
`else
          if (bit_cnt_q == (rec_bits_q - CNT_ONE)) begin
            state_d = WRITE;
          end
`endif
        end
      end

      WRITE: begin
        if (wr_ready) begin
          if (last_rec) begin
            state_d = DONE;
          end else begin
            rec_idx_d = rec_idx_q + ADDR_W'(1);
            shreg_d   = '0;
            bit_cnt_d = '0;
`ifdef SER_PARITY_EN
            par_d     = 1'b0;
`endif
            state_d   = SHIFT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      rec_idx_q   <= '0;
      num_q       <= '0;
      rec_bits_q  <= '0;
      base_q      <= '0;
      half_q      <= 1'b0;
      ser_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SER_PARITY_EN
      par_q       <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      rec_idx_q   <= rec_idx_d;
      num_q       <= num_d;
      rec_bits_q  <= rec_bits_d;
      base_q      <= base_d;
      half_q      <= half_d;
      ser_ready_q <= (state_d == SHIFT);
      wr_en_q     <= (state_d == WRITE);
      busy_q      <= (state_d == SHIFT) || (state_d == WRITE);
      done_q      <= (state_d == DONE);
`ifdef SER_PARITY_EN
      par_q       <= par_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign ser_ready = ser_ready_q;
  assign wr_en     = wr_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign half_flag = half_q;
  assign wr_addr   = rec_idx_q;
  // The shift register only leaves the block while a write is being offered.
  assign wr_data   = wr_en_q ? shreg_q : '0;
`ifdef SER_PARITY_EN
  assign par_err   = par_err_q;
`endif

endmodule
